cpu_controller: RTL and testbench

//  Sequencer for the 16-bit register/ALU datapath: fetches, decodes and executes one instruction at a time.

---
 rtl/cpu_pkg.sv | 75 +++++++
 rtl/cpu_instr_decode.sv | 66 ++++++
 rtl/cpu_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_cpu_controller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_controller sequencer and its instruction decoder.
// Branch-only encodings exist when CPU_BRANCH_EN is defined.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ST_W   = 5;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_RST  = 5'd0;
  localparam state_t S_IF1  = 5'd1;
  localparam state_t S_IF2  = 5'd2;
  localparam state_t S_UPC  = 5'd3;
  localparam state_t S_DEC  = 5'd4;
  localparam state_t S_MOVI = 5'd5;
  localparam state_t S_GETA = 5'd6;
  localparam state_t S_GETB = 5'd7;
  localparam state_t S_EXE  = 5'd8;
  localparam state_t S_WRB  = 5'd9;
  localparam state_t S_ADDR = 5'd10;
  localparam state_t S_MRD  = 5'd11;
  localparam state_t S_MWB  = 5'd12;
  localparam state_t S_LDAR = 5'd13;
  localparam state_t S_STB  = 5'd14;
  localparam state_t S_MWR  = 5'd15;
  localparam state_t S_HALT = 5'd16;
`ifdef CPU_BRANCH_EN
  localparam state_t S_BR   = 5'd17;
  localparam state_t S_BRX  = 5'd18;
  localparam state_t S_LINK = 5'd19;

  localparam logic [2:0] OPC_B  = 3'b001;
  localparam logic [2:0] OPC_BL = 3'b010;
  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_LE = 3'd4;
  localparam logic [1:0] VSEL_PC = 2'b11;
`endif

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_MEM = 2'b01;
  localparam logic [1:0] VSEL_IMM = 2'b10;
  localparam logic [1:0] BSEL_B    = 2'b00;
  localparam logic [1:0] BSEL_IMM5 = 2'b01;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [3:0] {
    I_ILL, I_MOVI, I_MOV, I_ADD, I_CMP, I_AND, I_MVN,
    I_LDR, I_STR, I_HALT, I_B, I_BL, I_BX, I_BLX
  } instr_t;

  // Instructions that run through the shifter/ALU with register operands.
  function automatic logic is_alu(input instr_t c);
    return c inside {I_MOV, I_ADD, I_CMP, I_AND, I_MVN};
  endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational split of the instruction register into fields, immediates and class.
// Branch classes are recognised only when CPU_BRANCH_EN is defined.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] ir_i,
  output instr_t            cls_o,
  output logic              legal_o,
  output logic [1:0]        op_o,
  output logic [2:0]        rn_o,
  output logic [2:0]        rd_o,
  output logic [2:0]        rm_o,
  output logic [2:0]        cond_o,
  output logic [1:0]        sh_o,
  output logic [DATA_W-1:0] sximm5_o,
  output logic [DATA_W-1:0] sximm8_o
);

  logic [2:0] opc;

  assign opc      = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign cond_o   = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

  always_comb begin
    cls_o = I_ILL;
    case (opc)
      OPC_MOV: begin
        if (op_o == 2'b10)      cls_o = I_MOVI;
        else if (op_o == 2'b00) cls_o = I_MOV;
      end
      OPC_ALU: begin
        case (op_o)
          ALU_ADD: cls_o = I_ADD;
          ALU_SUB: cls_o = I_CMP;
          ALU_AND: cls_o = I_AND;
          default: cls_o = I_MVN;
        endcase
      end
      OPC_LDR:  if (op_o == 2'b00) cls_o = I_LDR;
      OPC_STR:  if (op_o == 2'b00) cls_o = I_STR;
      OPC_HALT: cls_o = I_HALT;
`ifdef CPU_BRANCH_EN
      OPC_B:    if (op_o == 2'b00) cls_o = I_B;
      OPC_BL: begin
        case (op_o)
          2'b11:   cls_o = I_BL;
          2'b00:   cls_o = I_BX;
          2'b10:   cls_o = I_BLX;
          default: cls_o = I_ILL;
        endcase
      end
`endif
      default: cls_o = I_ILL;
    endcase
  end

  assign legal_o = (cls_o != I_ILL);

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer: owns PC, IR and DAR and drives all datapath and memory controls.
// Define CPU_BRANCH_EN to enable B/BL/BX/BLX; otherwise those opcodes halt.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [2:0]        status_in,
  input  logic [DATA_W-1:0] dp_out,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [1:0]        vsel,
  output logic [1:0]        bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              asel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, dar_q, dar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  mem_cmd_t          cmd_c;
  instr_t            cls;
  logic              legal, unused_bits;
  logic [1:0]        op, sh;
  logic [2:0]        rn, rd, rm, cond;

  cpu_instr_decode u_dec (
    .ir_i    (ir_q),
    .cls_o   (cls),
    .legal_o (legal),
    .op_o    (op),
    .rn_o    (rn),
    .rd_o    (rd),
    .rm_o    (rm),
    .cond_o  (cond),
    .sh_o    (sh),
    .sximm5_o(sximm5),
    .sximm8_o(sximm8)
  );

`ifdef CPU_BRANCH_EN
  logic taken_c, st_z, st_v, st_n;
  assign {st_z, st_v, st_n} = status_in;

  always_comb begin
    case (cond)
      COND_AL: taken_c = 1'b1;
      COND_EQ: taken_c = st_z;
      COND_NE: taken_c = !st_z;
      COND_LT: taken_c = (st_n != st_v);
      COND_LE: taken_c = (st_n != st_v) || st_z;
      default: taken_c = 1'b0;
    endcase
  end
  assign unused_bits = ^dp_out[DATA_W-1:ADDR_W];
`else
  assign unused_bits = ^{dp_out[DATA_W-1:ADDR_W], status_in, cond};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      pc_q    <= '0;
      ir_q    <= '0;
      dar_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dar_q   <= dar_d;
    end
  end

  // Next state and all controls, decoded from the current state and IR.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    dar_d    = dar_q;
    cmd_c    = MEM_NONE;
    mem_addr = pc_q;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = VSEL_C;
    bsel     = BSEL_B;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    asel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_RST: state_d = S_IF1;
      S_IF1: begin
        cmd_c   = MEM_READ;
        state_d = S_IF2;
      end
      S_IF2: begin
        cmd_c   = MEM_READ;
        ir_d    = mem_rdata;
        state_d = S_UPC;
      end
      S_UPC: begin
        pc_d    = pc_q + 8'd1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (!legal) state_d = S_HALT;
        else begin
          case (cls)
            I_MOVI:                             state_d = S_MOVI;
            I_MOV, I_MVN:                       state_d = S_GETB;
            I_ADD, I_AND, I_CMP, I_LDR, I_STR:  state_d = S_GETA;
`ifdef CPU_BRANCH_EN
            I_B:                                state_d = taken_c ? S_BR : S_IF1;
            I_BL:                               state_d = S_BR;
            I_BX, I_BLX:                        state_d = S_GETB;
`endif
            default:                            state_d = S_HALT;
          endcase
        end
      end
      S_MOVI: begin
        vsel     = VSEL_IMM;
        writenum = rn;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = (cls == I_LDR || cls == I_STR) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        readnum = is_alu(cls) ? rm : rd;
        loadb   = 1'b1;
        shift   = is_alu(cls) ? sh : 2'b00;
        state_d = (cls == I_STR) ? S_STB : S_EXE;
`ifdef CPU_BRANCH_EN
        if (cls == I_BLX) state_d = S_LINK;
`endif
      end
      S_EXE: begin
        shift = is_alu(cls) ? sh : 2'b00;
        asel  = !(cls inside {I_ADD, I_AND, I_CMP});
        ALUop = is_alu(cls) ? op : ALU_ADD;
        if (cls == I_CMP) begin
          loads   = 1'b1;
          state_d = S_IF1;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRB;
`ifdef CPU_BRANCH_EN
          if (cls == I_BX || cls == I_BLX) state_d = S_BRX;
`endif
        end
      end
      S_WRB: begin
        writenum = rd;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_ADDR: begin
        bsel    = BSEL_IMM5;
        loadc   = 1'b1;
        state_d = (cls == I_LDR) ? S_MRD : S_LDAR;
      end
      S_MRD: begin
        cmd_c    = MEM_READ;
        mem_addr = dp_out[ADDR_W-1:0];
        state_d  = S_MWB;
      end
      S_MWB: begin
        cmd_c    = MEM_READ;
        mem_addr = dp_out[ADDR_W-1:0];
        vsel     = VSEL_MEM;
        writenum = rd;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_LDAR: begin
        dar_d   = dp_out[ADDR_W-1:0];
        state_d = S_GETB;
      end
      S_STB: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_MWR;
      end
      S_MWR: begin
        cmd_c    = MEM_WRITE;
        mem_addr = dar_q;
        state_d  = S_IF1;
      end
`ifdef CPU_BRANCH_EN
      S_BR: begin
        pc_d = pc_q + sximm8[ADDR_W-1:0];
        if (cls == I_BL) begin
          vsel     = VSEL_PC;
          writenum = 3'd7;
          write    = 1'b1;
        end
        state_d = S_IF1;
      end
      S_LINK: begin
        vsel     = VSEL_PC;
        writenum = 3'd7;
        write    = 1'b1;
        state_d  = S_EXE;
      end
      S_BRX: begin
        pc_d    = dp_out[ADDR_W-1:0];
        state_d = S_IF1;
      end
`endif
      S_HALT:  halted  = 1'b1;
      default: state_d = S_RST;
    endcase
  end

  assign mem_cmd = cmd_c;
  assign pc      = pc_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: a small datapath/memory environment plus an instruction-level reference model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mem_rdata, dp_out, sximm8, sximm5;
  logic [2:0]  status_in, readnum, writenum;
  logic [1:0]  mem_cmd, vsel, bsel, shift, ALUop;
  logic [7:0]  mem_addr, pc;
  logic        asel, loada, loadb, loadc, loads, write, halted;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata), .status_in(status_in), .dp_out(dp_out),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .readnum(readnum), .writenum(writenum),
    .vsel(vsel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .asel(asel), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .write(write), .sximm8(sximm8),
    .sximm5(sximm5), .pc(pc), .halted(halted)
  );

  // Environment: register file, A/B/C/status, shifter/ALU and unified memory.
  logic [15:0] img [256];
  logic [15:0] mem [256];
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc, bsh, ain, bin, alu, vdata;
  logic [2:0]  st;
  logic        ovf, load;

  always_comb begin
    case (shift)
      2'b01:   bsh = rb << 1;
      2'b10:   bsh = rb >> 1;
      2'b11:   bsh = {rb[15], rb[15:1]};
      default: bsh = rb;
    endcase
    ain = asel ? 16'h0000 : ra;
    bin = (bsel == 2'b01) ? sximm5 : bsh;
    case (ALUop)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
    ovf = (ALUop == 2'b01) ? ((ain[15] != bin[15]) && (alu[15] != ain[15]))
                           : ((ain[15] == bin[15]) && (alu[15] != ain[15]));
    case (vsel)
      2'b00:   vdata = rc;
      2'b01:   vdata = mem_rdata;
      2'b10:   vdata = sximm8;
      default: vdata = {8'h00, pc};
    endcase
  end

  assign dp_out    = rc;
  assign status_in = st;

  always @(posedge clk) begin
    if (load) begin
      mem <= img;
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      ra <= '0; rb <= '0; rc <= '0; st <= '0; mem_rdata <= '0;
    end else begin
      if (write) rf[writenum] <= vdata;
      if (loada) ra <= rf[readnum];
      if (loadb) rb <= rf[readnum];
      if (loadc) rc <= alu;
      if (loads) st <= {alu == 16'h0000, ovf, alu[15]};
      if (mem_cmd == 2'b01) mem_rdata <= mem[mem_addr];
      if (mem_cmd == 2'b10) mem[mem_addr] <= rc;
    end
  end

  int total = 0, bad = 0;
  int cycles, n_loads, n_writes, n_rd8, n_wr;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] exp_rf [8];
  logic [15:0] exp_mem [256];
  int exp_cyc;

  function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] s);
    case (s)
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      2'b11:   return {b[15], b[15:1]};
      default: return b;
    endcase
  endfunction

  // Instruction-at-a-time model: architectural effect and cycle cost of each instruction.
  task automatic model_run();
    logic [15:0] ir, a, b, s5, s8;
    logic [7:0]  p;
    logic        done;
    exp_mem = img;
    for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0000;
    p = 8'h00; exp_cyc = 1; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      ir = exp_mem[p];
      p  = p + 8'd1;
      s5 = {{11{ir[4]}}, ir[4:0]};
      s8 = {{8{ir[7]}}, ir[7:0]};
      a  = exp_rf[ir[10:8]];
      b  = shf(exp_rf[ir[2:0]], ir[4:3]);
      case (ir[15:11])
        5'b110_10: begin exp_rf[ir[10:8]] = s8;                    exp_cyc += 5;  end
        5'b110_00: begin exp_rf[ir[7:5]] = b;                      exp_cyc += 7;  end
        5'b101_00: begin exp_rf[ir[7:5]] = a + b;                  exp_cyc += 8;  end
        5'b101_10: begin exp_rf[ir[7:5]] = a & b;                  exp_cyc += 8;  end
        5'b101_11: begin exp_rf[ir[7:5]] = ~b;                     exp_cyc += 7;  end
        5'b101_01: begin                                           exp_cyc += 7;  end
        5'b011_00: begin exp_rf[ir[7:5]] = exp_mem[8'(a + s5)];    exp_cyc += 8;  end
        5'b100_00: begin exp_mem[8'(a + s5)] = exp_rf[ir[7:5]];    exp_cyc += 10; end
        default:   begin done = 1'b1;                              exp_cyc += 4;  end
      endcase
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic launch();
    reset_n = 1'b0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    cycles = 0; n_loads = 0; n_writes = 0; n_rd8 = 0; n_wr = 0; wr_addr = '0; wr_data = '0;
    reset_n = 1'b1;
  endtask

  task automatic run_prog(input int budget);
    launch();
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (loads) n_loads++;
      if (write) n_writes++;
      if (mem_cmd == 2'b01 && mem_addr == 8'h08) n_rd8++;
      if (mem_cmd == 2'b10) begin n_wr++; wr_addr = mem_addr; wr_data = dp_out; end
    end
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL run_halt: halted=%b after %0d cycles, want 1", halted, cycles); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({mem_cmd, write, loada, loadb, loadc, loads, halted} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000", {mem_cmd, write, loada, loadb, loadc, loads, halted});
    end
    total++;
    if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
  endtask

  task automatic test_basic();
    clear_img();
    img[0] = 16'hD007; img[1] = 16'hD102; img[2] = 16'hA148; img[3] = 16'hE000;
    run_prog(100);
    total++; if (rf[0] !== 16'd7)  begin bad++; $display("FAIL basic_r0: got %h want 0007", rf[0]); end
    total++; if (rf[1] !== 16'd2)  begin bad++; $display("FAIL basic_r1: got %h want 0002", rf[1]); end
    total++; if (rf[2] !== 16'd16) begin bad++; $display("FAIL basic_r2: got %h want 0010", rf[2]); end
    total++; if (cycles != 23)     begin bad++; $display("FAIL basic_cycles: got %0d want 23", cycles); end
  endtask

  task automatic test_cmp();
    clear_img();
    img[0] = 16'hD305; img[1] = 16'hAB03; img[2] = 16'hE000;
    run_prog(100);
    total++; if (n_loads != 1)  begin bad++; $display("FAIL cmp_loads: got %0d want 1", n_loads); end
    total++; if (st[2] !== 1'b1) begin bad++; $display("FAIL cmp_z: got %b want 1", st[2]); end
    total++; if (n_writes != 1) begin bad++; $display("FAIL cmp_writes: got %0d want 1", n_writes); end
    total++; if (rf[3] !== 16'd5) begin bad++; $display("FAIL cmp_r3: got %h want 0005", rf[3]); end
  endtask

  task automatic test_ldr();
    clear_img();
    img[0] = 16'hD007; img[1] = 16'h6081; img[2] = 16'hE000; img[8] = 16'h1234;
    run_prog(100);
    total++; if (n_rd8 != 2) begin bad++; $display("FAIL ldr_reads: got %0d want 2", n_rd8); end
    total++; if (rf[4] !== 16'h1234) begin bad++; $display("FAIL ldr_r4: got %h want 1234", rf[4]); end
  endtask

  task automatic test_str();
    clear_img();
    img[0] = 16'hD007; img[1] = 16'hD1A5; img[2] = 16'h8021; img[3] = 16'hE000;
    run_prog(100);
    total++; if (n_wr != 1) begin bad++; $display("FAIL str_writes: got %0d want 1", n_wr); end
    total++; if (wr_addr !== 8'h08) begin bad++; $display("FAIL str_addr: got %h want 08", wr_addr); end
    total++; if (wr_data !== 16'hFFA5) begin bad++; $display("FAIL str_data: got %h want ffa5", wr_data); end
    total++; if (mem[8] !== 16'hFFA5) begin bad++; $display("FAIL str_mem: got %h want ffa5", mem[8]); end
  endtask

  task automatic check_halt_word(input logic [15:0] w);
    int busy;
    clear_img();
    img[0] = w;
    run_prog(50);
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_cmd !== 2'b00 || halted !== 1'b1) busy++;
    end
    total++; if (busy != 0) begin bad++; $display("FAIL halt_idle %h: %0d active cycles, want 0", w, busy); end
    total++; if (cycles != 5) begin bad++; $display("FAIL halt_cycles %h: got %0d want 5", w, cycles); end
  endtask

  task automatic test_illegal();
    check_halt_word(16'h0000);
`ifndef CPU_BRANCH_EN
    check_halt_word(16'h2000);
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    clear_img();
    img[0] = 16'hD007; img[1] = 16'hD102; img[2] = 16'hA148; img[3] = 16'hE000;
    launch();
    n = 0;
    while (!(loadc === 1'b1 && asel === 1'b0) && n < 60) begin @(negedge clk); n++; end
    total++;
    if (n >= 60) begin bad++; $display("FAIL rmid_exe: EXE not seen in %0d cycles", n); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({mem_cmd, write, loada, loadb, loadc, loads, pc} !== 15'h0000) begin
      bad++; $display("FAIL rmid_ctrl: got %h want 0000", {mem_cmd, write, loada, loadb, loadc, loads, pc});
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (mem_cmd !== 2'b01 || mem_addr !== 8'h00) begin
      bad++; $display("FAIL rmid_fetch: cmd=%b addr=%h want 01/00", mem_cmd, mem_addr);
    end
    n = 0;
    while (!halted && n < 100) begin @(negedge clk); n++; end
    total++; if (rf[2] !== 16'd16) begin bad++; $display("FAIL rmid_r2: got %h want 0010", rf[2]); end
  endtask

`ifdef CPU_BRANCH_EN
  task automatic test_branch();
    clear_img();
    img[0] = 16'hD305; img[1] = 16'hAB03; img[2] = 16'h2102;
    img[3] = 16'hD201; img[4] = 16'hD201; img[5] = 16'hD009; img[6] = 16'hE000;
    run_prog(100);
    total++; if (rf[0] !== 16'd9) begin bad++; $display("FAIL beq_r0: got %h want 0009", rf[0]); end
    total++; if (rf[2] !== 16'd0) begin bad++; $display("FAIL beq_skip: got %h want 0000", rf[2]); end
    total++; if (cycles != 27)   begin bad++; $display("FAIL beq_cycles: got %0d want 27", cycles); end
  endtask
`endif

  task automatic test_random();
    int n, k;
    logic [15:0] w;
    logic [2:0]  rd, rn, rm;
    logic [1:0]  sh;
    for (int t = 0; t < 6; t++) begin
      clear_img();
      for (int a = 128; a < 256; a++) img[a] = 16'($urandom);
      img[0] = 16'hD690;
      n = $urandom_range(6, 20);
      for (int i = 1; i <= n; i++) begin
        k  = $urandom_range(0, 7);
        rd = 3'($urandom_range(0, 5));
        rn = 3'($urandom_range(0, 6));
        rm = 3'($urandom_range(0, 7));
        sh = 2'($urandom);
        case (k)
          0:       w = {3'b110, 2'b10, rd, 8'($urandom)};
          1:       w = {3'b110, 2'b00, 3'b000, rd, sh, rm};
          6:       w = {3'b011, 2'b00, 3'd6, rd, 5'($urandom)};
          7:       w = {3'b100, 2'b00, 3'd6, rm, 5'($urandom)};
          default: w = {3'b101, 2'(k - 2), rn, rd, sh, rm};
        endcase
        img[i] = w;
      end
      img[n + 1] = 16'hE000;
      model_run();
      run_prog(400);
      for (int r = 0; r < 8; r++) begin
        total++;
        if (rf[r] !== exp_rf[r]) begin bad++; $display("FAIL rand%0d_r%0d: got %h want %h", t, r, rf[r], exp_rf[r]); end
      end
      for (int a = 128; a < 160; a++) begin
        total++;
        if (mem[a] !== exp_mem[a]) begin bad++; $display("FAIL rand%0d_mem%h: got %h want %h", t, a[7:0], mem[a], exp_mem[a]); end
      end
      total++;
      if (cycles != exp_cyc) begin bad++; $display("FAIL rand%0d_cycles: got %0d want %0d", t, cycles, exp_cyc); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    clear_img();
    test_reset();
    test_basic();
    test_cmp();
    test_ldr();
    test_str();
    test_illegal();
    test_reset_mid();
`ifdef CPU_BRANCH_EN
    test_branch();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
